// File: rtl/axi_lite_mem_slave.sv
// ---------------------------------------------------------------------------
// axi_lite_mem_slave
// AXI4-Lite responder backed by a word-addressed on-chip RAM. Serves
// single-beat 32-bit reads and writes with byte strobes. The read and write
// channels run independent FSMs, so one read and one write can be in flight
// at the same time.
//
// Parameters
//   DEPTH_LOG2  RAM holds 2**DEPTH_LOG2 32-bit words; word index is
//               addr[DEPTH_LOG2+1:2]
//
// Ports
//   clk, rstn                     clock, asynchronous active-low reset
//   s_ar*  (addr/valid/ready/prot) read address channel (prot ignored)
//   s_r*   (data/resp/valid/ready) read data channel
//   s_aw*  (addr/valid/ready/prot) write address channel (prot ignored)
//   s_w*   (data/strb/valid/ready) write data channel
//   s_b*   (resp/valid/ready)      write response channel
//
// Build option
//   ADDR_ERR_EN  when defined, any address bit above DEPTH_LOG2+1 produces a
//                SLVERR response (writes dropped, reads return 0). When
//                undefined, upper address bits alias and responses are OKAY.
// ---------------------------------------------------------------------------
module axi_lite_mem_slave #(
  parameter int unsigned DEPTH_LOG2 = 12
) (
  input  logic        clk,
  input  logic        rstn,
  // read address channel
  input  logic [31:0] s_araddr,
  input  logic        s_arvalid,
  output logic        s_arready,
  input  logic [2:0]  s_arprot,
  // read data channel
  output logic [31:0] s_rdata,
  output logic [1:0]  s_rresp,
  output logic        s_rvalid,
  input  logic        s_rready,
  // write address channel
  input  logic [31:0] s_awaddr,
  input  logic        s_awvalid,
  output logic        s_awready,
  input  logic [2:0]  s_awprot,
  // write data channel
  input  logic [31:0] s_wdata,
  input  logic [3:0]  s_wstrb,
  input  logic        s_wvalid,
  output logic        s_wready,
  // write response channel
  output logic [1:0]  s_bresp,
  output logic        s_bvalid,
  input  logic        s_bready
);

  localparam int unsigned DEPTH    = 1 << DEPTH_LOG2;
  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned STRB_W   = DATA_W / 8;
  localparam int unsigned RESP_W   = 2;
  localparam int unsigned IDX_HI   = DEPTH_LOG2 + 1;
  localparam logic [RESP_W-1:0] RESP_OKAY   = 2'b00;
  localparam logic [RESP_W-1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {R_IDLE, R_DATA} r_state_e;
  typedef enum logic {W_IDLE, W_RESP} w_state_e;

  // Storage array (contents are not reset)
  logic [DATA_W-1:0] mem [DEPTH];

  // Read channel state
  r_state_e            r_state_q, r_state_d;
  logic                arready_q, arready_d;
  logic                rvalid_q,  rvalid_d;
  logic [DATA_W-1:0]   rdata_q,   rdata_d;
  logic [RESP_W-1:0]   rresp_q,   rresp_d;

  // Write channel state, including the AW/W holding registers
  w_state_e            w_state_q, w_state_d;
  logic                awready_q, awready_d;
  logic                wready_q,  wready_d;
  logic                bvalid_q,  bvalid_d;
  logic [RESP_W-1:0]   bresp_q,   bresp_d;
  logic                aw_held_q, aw_held_d;
  logic [ADDR_W-1:0]   aw_addr_q, aw_addr_d;
  logic                w_held_q,  w_held_d;
  logic [DATA_W-1:0]   w_data_q,  w_data_d;
  logic [STRB_W-1:0]   w_strb_q,  w_strb_d;

  // Combinational helpers
  logic                  ar_fire_c;
  logic                  aw_fire_c;
  logic                  w_fire_c;
  logic [DEPTH_LOG2-1:0] rd_idx_c;
  logic [ADDR_W-1:0]     wr_addr_c;
  logic [DATA_W-1:0]     wr_data_c;
  logic [STRB_W-1:0]     wr_strb_c;
  logic [DEPTH_LOG2-1:0] wr_idx_c;
  logic                  rd_err_c;
  logic                  wr_err_c;
  logic                  mem_we_c;
  logic                  unused_c;

  assign ar_fire_c = s_arvalid & arready_q;
  assign aw_fire_c = s_awvalid & awready_q;
  assign w_fire_c  = s_wvalid  & wready_q;

  // Write operands come from the holding regs once captured, else from the bus
  assign wr_addr_c = aw_held_q ? aw_addr_q : s_awaddr;
  assign wr_data_c = w_held_q  ? w_data_q  : s_wdata;
  assign wr_strb_c = w_held_q  ? w_strb_q  : s_wstrb;

  assign rd_idx_c  = s_araddr[IDX_HI:2];
  assign wr_idx_c  = wr_addr_c[IDX_HI:2];

`ifdef ADDR_ERR_EN
  // Any bit above the RAM's byte range flags an out-of-range access
  assign rd_err_c = (s_araddr  >> (DEPTH_LOG2 + 2)) != '0;
  assign wr_err_c = (wr_addr_c >> (DEPTH_LOG2 + 2)) != '0;
`else
  assign rd_err_c = 1'b0;
  assign wr_err_c = 1'b0;
`endif

  // Protection bits and byte-offset/upper address bits carry no meaning here
  assign unused_c = ^{s_arprot, s_awprot, s_araddr, wr_addr_c};

  // Read FSM: capture AR, return data one cycle later, hold until R handshake
  always_comb begin
    r_state_d = r_state_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    arready_d = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        if (ar_fire_c) begin
          r_state_d = R_DATA;
          rvalid_d  = 1'b1;
          if (rd_err_c) begin
            rdata_d = '0;
            rresp_d = RESP_SLVERR;
          end else begin
            rdata_d = mem[rd_idx_c];
            rresp_d = RESP_OKAY;
          end
        end
      end
      R_DATA: begin
        if (s_rready) begin
          r_state_d = R_IDLE;
          rvalid_d  = 1'b0;
        end
      end
    endcase
    // arready follows the next state, so it stays low on the R handshake cycle
    arready_d = (r_state_d == R_IDLE);
  end

  // Write FSM: collect AW and W in any order, commit, then hold B until taken
  always_comb begin
    w_state_d = w_state_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    aw_held_d = aw_held_q;
    aw_addr_d = aw_addr_q;
    w_held_d  = w_held_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    mem_we_c  = 1'b0;
    awready_d = 1'b0;
    wready_d  = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (aw_fire_c) begin
          aw_held_d = 1'b1;
          aw_addr_d = s_awaddr;
        end
        if (w_fire_c) begin
          w_held_d = 1'b1;
          w_data_d = s_wdata;
          w_strb_d = s_wstrb;
        end
        // Commit as soon as both halves are present, including capture cycle
        if (aw_held_d && w_held_d) begin
          mem_we_c  = ~wr_err_c;
          bvalid_d  = 1'b1;
          bresp_d   = wr_err_c ? RESP_SLVERR : RESP_OKAY;
          w_state_d = W_RESP;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
        end
      end
      W_RESP: begin
        if (s_bready) begin
          bvalid_d  = 1'b0;
          w_state_d = W_IDLE;
        end
      end
    endcase
    awready_d = (w_state_d == W_IDLE) && !aw_held_d;
    wready_d  = (w_state_d == W_IDLE) && !w_held_d;
  end

  // RAM write port with byte enables; same-edge reads see the old word
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      for (int b = 0; b < int'(STRB_W); b++) begin
        if (wr_strb_c[b]) begin
          mem[wr_idx_c][8*b +: 8] <= wr_data_c[8*b +: 8];
        end
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= '0;
      w_state_q <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= '0;
      aw_held_q <= 1'b0;
      aw_addr_q <= '0;
      w_held_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
    end else begin
      r_state_q <= r_state_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      w_state_q <= w_state_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      aw_held_q <= aw_held_d;
      aw_addr_q <= aw_addr_d;
      w_held_q  <= w_held_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
    end
  end

  assign s_arready = arready_q;
  assign s_rvalid  = rvalid_q;
  assign s_rdata   = rdata_q;
  assign s_rresp   = rresp_q;
  assign s_awready = awready_q;
  assign s_wready  = wready_q;
  assign s_bvalid  = bvalid_q;
  assign s_bresp   = bresp_q;

endmodule
